// File: rtl/m_pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage register.
package m_pipe_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned CTRL_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/m_pipe_stage_reg_if.sv
// Upstream/downstream handshake and payload bundle for m_pipe_stage_reg.
// master = the side driving in_* and consuming out_*; slave = the stage itself.
interface m_pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = m_pipe_pkg::CTRL_W_DEF,
    parameter int unsigned DATA_W = m_pipe_pkg::DATA_W_DEF
);
    localparam int unsigned INSTR_W = m_pipe_pkg::INSTR_W;

    logic               in_valid;
    logic               in_ready;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [DATA_W-1:0]  in_data;
    logic [INSTR_W-1:0] in_instr;

    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [DATA_W-1:0]  out_data;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output in_valid, in_ctrl, in_data, in_instr, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_instr
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_instr, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_instr
    );

endinterface

// File: rtl/m_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module m_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/m_pipe_stage_reg.sv
// Two-entry elastic pipeline stage (main + skid) with flush and bubble counter.
// Define M_PIPE_TRACE_EN to print each instruction leaving the stage.
module m_pipe_stage_reg
    import m_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CNT_W      = 16,
    parameter string       STAGE_NAME = "EX"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    m_pipe_stage_reg_if.slave bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_e state_q;
    state_e state_d;

    logic [CTRL_W-1:0]  main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q,  main_data_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [CTRL_W-1:0]  skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q,  skid_data_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic in_ready_q,  in_ready_d;
    logic out_valid_q, out_valid_d;

    // Next state and entry movement; flush wins over every handshake.
    always_comb begin
        state_d      = state_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_instr_d = main_instr_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_instr_d = skid_instr_q;

        unique case (state_q)
            EMPTY: begin
                if (bus.in_valid) begin
                    main_ctrl_d  = bus.in_ctrl;
                    main_data_d  = bus.in_data;
                    main_instr_d = bus.in_instr;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (bus.in_valid && bus.out_ready) begin
                    main_ctrl_d  = bus.in_ctrl;
                    main_data_d  = bus.in_data;
                    main_instr_d = bus.in_instr;
                end else if (bus.in_valid) begin
                    skid_ctrl_d  = bus.in_ctrl;
                    skid_data_d  = bus.in_data;
                    skid_instr_d = bus.in_instr;
                    state_d      = FULL;
                end else if (bus.out_ready) begin
                    // Bubble must carry no control; data/instr keep the last head.
                    main_ctrl_d = '0;
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    main_ctrl_d  = skid_ctrl_q;
                    main_data_d  = skid_data_q;
                    main_instr_d = skid_instr_q;
                    skid_ctrl_d  = '0;
                    skid_data_d  = '0;
                    skid_instr_d = '0;
                    state_d      = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d      = EMPTY;
            main_ctrl_d  = '0;
            main_data_d  = '0;
            main_instr_d = '0;
            skid_ctrl_d  = '0;
            skid_data_d  = '0;
            skid_instr_d = '0;
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_instr_q <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_instr_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_instr_q <= main_instr_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_instr_q <= skid_instr_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_instr = main_instr_q;

    // Counts cycles where downstream was ready but received nothing.
    m_sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.out_ready & ~out_valid_q),
        .count (bubble_cnt)
    );

`ifdef M_PIPE_TRACE_EN
    always @(posedge clk) begin
        if (!reset && (out_valid_q === 1'b1) && (bus.out_ready === 1'b1)) begin
            $display("Instruction %h is in %s stage", main_instr_q, STAGE_NAME);
        end
    end
`else
    // Trace disabled: no simulation output from this stage.
`endif

endmodule

// File: doc/m_pipe_stage_reg.md
M_PIPE_STAGE_REG -- requirements
Module: m_pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 10: control-field width (regwrite, memtoreg, memwrite, alucontrol, alusrc, regdst, ...).
REQ-002 Parameter DATA_W, default 101: datapath payload width (operands, immediate, register indices).
REQ-003 Parameter CNT_W, default 16: bubble-counter width.
REQ-004 Parameter STAGE_NAME, default "EX": stage label for trace output.
REQ-005 One clock, clk; reset is synchronous and active-high, named reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 flush  in  1  discard all held entries.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_ready  out  1  stage can accept; registered, equals (state != FULL).
REQ-011 in_ctrl / in_data / in_instr  in  CTRL_W / DATA_W / 32  upstream payload.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_ready  in  1  downstream accepts head.
REQ-014 out_ctrl / out_data / out_instr  out  CTRL_W / DATA_W / 32  head payload.
REQ-015 bubble_cnt  out  CNT_W  saturating count of downstream idle cycles.

Function
REQ-016 Two-entry elastic stage (main + skid); states EMPTY, BUSY (main only), FULL (main + skid).
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-018 EMPTY: in_valid -> main <= input, BUSY; else stay EMPTY.
REQ-019 BUSY: in_valid & out_ready -> main <= input, stay BUSY; in_valid & !out_ready -> skid <= input, FULL; !in_valid & out_ready -> EMPTY; neither -> hold.
REQ-020 FULL: out_ready -> main <= skid, BUSY; else hold; in_valid ignored (in_ready=0).
REQ-021 Latency: entry accepted at edge N is on outputs, out_valid=1, after edge N; sustained throughput one entry per cycle.
REQ-022 Order preserved; no entry duplicated or dropped except on flush/reset.
REQ-023 out_valid = (state != EMPTY).
REQ-024 out_ctrl forced to all-zero whenever out_valid=0, so a bubble never writes registers or memory.
REQ-025 out_data and out_instr are zero after reset or flush until the next load; otherwise they hold the head entry.
REQ-026 flush has priority over every transition: next state EMPTY, both entries zeroed, any same-cycle input discarded, the same-cycle out transfer still counts as taken by downstream.
REQ-027 bubble_cnt increments by 1 on each cycle with out_ready=1 and out_valid=0; saturates at 2^CNT_W-1; never wraps.
REQ-028 Hold with out_ready=0 keeps all outputs bit-stable.

Reset
REQ-029 reset=1 at a rising edge: state EMPTY, in_ready=1, out_valid=0, out_ctrl/out_data/out_instr=0, bubble_cnt=0, skid zeroed.
REQ-030 reset overrides flush and all handshakes; mid-operation reset discards both entries.

Configuration
REQ-031 Macro M_PIPE_TRACE_EN defined: on every out transfer, print "Instruction <out_instr hex> is in <STAGE_NAME> stage" once, only when out_valid=1 (no X comparisons).
REQ-032 M_PIPE_TRACE_EN undefined: no display statements compiled; identical cycle behaviour.

Structure
REQ-033 Package m_pipe_pkg holds the state enum typedef (EMPTY, BUSY, FULL), INSTR_W=32, and default CTRL_W/DATA_W constants.
REQ-034 Sub-module m_sat_counter (parameter WIDTH; inputs clk, reset, inc; output count) implements bubble_cnt.

Verification
REQ-035 Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_ctrl=0, bubble_cnt=0.
REQ-036 Streaming: out_ready=1, instr 0x20080005, 0x20090007, 0x01095020 on consecutive cycles -> same three on out_instr on cycles 1-3, in_ready always 1.
REQ-037 Backpressure: out_ready=0, push 0xAAAA0001, 0xAAAA0002 -> FULL, in_ready=0; 0xAAAA0003 held upstream; release out_ready -> 0x..01, 0x..02, 0x..03 in order, none lost.
REQ-038 Flush in FULL with simultaneous in_valid (instr 0x12345678) -> next cycle out_valid=0, out_ctrl=0, out_instr=0, in_ready=1; 0x12345678 never appears.
REQ-039 Bubble saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15, stays 15.
REQ-040 Trace: build with M_PIPE_TRACE_EN, push 0x8C100004 -> exactly one line "Instruction 8c100004 is in EX stage"; without macro -> no output.
